// File: rtl/wino_pkg.sv
// Shared definitions for the Winograd F(2x2,3x3) tile engine.
//   - default element widths
//   - B^T, G' (= 2G) and A^T coefficient tables
//   - tile packing index helpers
//   - data, filter and output transforms as combinational functions
// The transforms work on 32-bit int matrices, so every width used with them
// must be 32 bits or less.
package wino_pkg;

    localparam int WI_DEF   = 8;
    localparam int WWI_DEF  = 12;
    localparam int WWO_DEF  = 24;
    localparam int WACC_DEF = 28;
    localparam int WO_DEF   = 32;

    // G' = 2G makes the filter transform integer-only. The output picks up a
    // factor of 4 from G' on both sides, which this shift removes exactly.
    localparam int G_SHIFT = 2;

    typedef int mat44_t [4][4];
    typedef int mat33_t [3][3];
    typedef int mat24_t [2][4];
    typedef int mat22_t [2][2];

    localparam int BT [4][4] = '{'{1,  0, -1,  0},
                                 '{0,  1,  1,  0},
                                 '{0, -1,  1,  0},
                                 '{0,  1,  0, -1}};

    localparam int GP [4][3] = '{'{2,  0,  0},
                                 '{1,  1,  1},
                                 '{1, -1,  1},
                                 '{0,  0,  2}};

    localparam int AT [2][4] = '{'{1,  1,  1,  0},
                                 '{0,  1, -1, -1}};

    function automatic int idx_d(input int r, input int c);
        return 4 * r + c;
    endfunction

    function automatic int idx_g(input int r, input int c);
        return 3 * r + c;
    endfunction

    function automatic int idx_y(input int i, input int j);
        return 2 * i + j;
    endfunction

    // U = B^T d B
    function automatic mat44_t data_xform(input mat44_t d);
        mat44_t u;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                u[i][j] = 0;
                for (int k = 0; k < 4; k++) begin
                    for (int l = 0; l < 4; l++) begin
                        u[i][j] += BT[i][k] * d[k][l] * BT[j][l];
                    end
                end
            end
        end
        return u;
    endfunction

    // V = G' g G'^T
    function automatic mat44_t filter_xform(input mat33_t g);
        mat44_t v;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                v[i][j] = 0;
                for (int k = 0; k < 3; k++) begin
                    for (int l = 0; l < 3; l++) begin
                        v[i][j] += GP[i][k] * g[k][l] * GP[j][l];
                    end
                end
            end
        end
        return v;
    endfunction

    // T = A^T S (row half of the output transform)
    function automatic mat24_t out_row_xform(input mat44_t s);
        mat24_t t;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) begin
                t[i][j] = 0;
                for (int k = 0; k < 4; k++) begin
                    t[i][j] += AT[i][k] * s[k][j];
                end
            end
        end
        return t;
    endfunction

    // Y' = T A (column half of the output transform)
    function automatic mat22_t out_col_xform(input mat24_t t);
        mat22_t y;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                y[i][j] = 0;
                for (int l = 0; l < 4; l++) begin
                    y[i][j] += t[i][l] * AT[j][l];
                end
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/wino_acc_stage.sv
// Winograd-domain channel accumulator.
// Sums the 16 element-wise products of every valid beat into acc. A beat
// tagged last hands the completed sum to the output transform and marks the
// accumulator empty, so the next beat starts a fresh group.
// Ports:
//   clk, rstn         clock, synchronous active-low reset
//   en                global advance enable; everything holds when low
//   m_valid, m_last   product beat valid / last channel of the group
//   m                 16 signed products, WWO bits each
//   sum, sum_valid    finished group sum (WACC bits each) and its valid
module wino_acc_stage
    import wino_pkg::*;
#(
    parameter int WWO  = WWO_DEF,
    parameter int WACC = WACC_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic                   m_valid,
    input  logic                   m_last,
    input  logic signed [WWO-1:0]  m [16],
    output logic signed [WACC-1:0] sum [16],
    output logic                   sum_valid
);

    logic signed [WACC-1:0] acc      [16];
    logic signed [WACC-1:0] acc_next [16];
    logic                   acc_empty;

    // An empty accumulator contributes zero rather than being cleared on the
    // last beat, so a new group can start in the cycle right after one ends.
    // Sums wrap modulo 2^WACC.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            acc_next[k] = (acc_empty ? '0 : acc[k]) + WACC'(m[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_empty <= 1'b1;
            sum_valid <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                acc[k] <= '0;
                sum[k] <= '0;
            end
        end else if (en) begin
            sum_valid <= m_valid && m_last;
            if (m_valid) begin
                acc_empty <= m_last;
                for (int k = 0; k < 16; k++) begin
                    acc[k] <= acc_next[k];
                end
                if (m_last) begin
                    for (int k = 0; k < 16; k++) begin
                        sum[k] <= acc_next[k];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/wino_conv_tile_acc.sv
// Streaming Winograd F(2x2,3x3) tile engine with input-channel accumulation.
// Each accepted beat carries one 4x4 data tile and one 3x3 filter of a single
// input channel. The products U.*V are summed across channels in the
// Winograd domain, and one output transform runs per group.
// Pipeline: S1 transforms, S2 products, S3 accumulate, S4a A^T S, S4b (.)A
// and the scale shift into Y. A last beat accepted at edge t shows
// out_valid at edge t+4 when nothing stalls.
// Ports:
//   clk, rstn                     clock, synchronous active-low reset
//   in_valid, in_ready, in_last   input beat handshake and group end
//   filter                        3x3 filter, (r,c) at [(3r+c)*WI +: WI]
//   data                          4x4 tile,   (r,c) at [(4r+c)*WI +: WI]
//   out_valid, out_ready          result handshake
//   Y                             2x2 result, (i,j) at [(2i+j)*WO +: WO]
module wino_conv_tile_acc
    import wino_pkg::*;
#(
    parameter int WI   = WI_DEF,
    parameter int WWI  = WWI_DEF,
    parameter int WWO  = WWO_DEF,
    parameter int WACC = WACC_DEF,
    parameter int WO   = WO_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [9*WI-1:0]  filter,
    input  logic [16*WI-1:0] data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4*WO-1:0]  Y
);

    // One enable for the whole pipeline: it advances only when the output
    // register is free or being drained this cycle.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = rstn && en;

    // ---------------- S1: input and filter transforms ----------------
    mat44_t d_m;
    mat33_t g_m;
    mat44_t u_m;
    mat44_t v_m;

    always_comb begin
        d_m = '{default: 0};
        g_m = '{default: 0};
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                d_m[r][c] = int'(signed'(data[idx_d(r, c)*WI +: WI]));
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                g_m[r][c] = int'(signed'(filter[idx_g(r, c)*WI +: WI]));
            end
        end
        u_m = data_xform(d_m);
        v_m = filter_xform(g_m);
    end

    logic signed [WWI-1:0] s1_u [16];
    logic signed [WWI-1:0] s1_v [16];
    logic                  s1_valid;
    logic                  s1_last;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    s1_u[idx_d(r, c)] <= WWI'(u_m[r][c]);
                    s1_v[idx_d(r, c)] <= WWI'(v_m[r][c]);
                end
            end
        end
    end

    // ---------------- S2: element-wise product ----------------
    logic signed [WWO-1:0] s2_m [16];
    logic                  s2_valid;
    logic                  s2_last;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            for (int k = 0; k < 16; k++) begin
                s2_m[k] <= WWO'(s1_u[k]) * WWO'(s1_v[k]);
            end
        end
    end

    // ---------------- S3: channel accumulation ----------------
    logic signed [WACC-1:0] s3_sum [16];
    logic                   s3_valid;

    wino_acc_stage #(
        .WWO  (WWO),
        .WACC (WACC)
    ) u_acc (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .m_valid   (s2_valid),
        .m_last    (s2_last),
        .m         (s2_m),
        .sum       (s3_sum),
        .sum_valid (s3_valid)
    );

    // ---------------- S4a: row half of the output transform ----------------
    mat44_t s_m;
    mat24_t t_m;

    always_comb begin
        s_m = '{default: 0};
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                s_m[r][c] = int'(s3_sum[idx_d(r, c)]);
            end
        end
        t_m = out_row_xform(s_m);
    end

    logic signed [WO-1:0] s4_t [2][4];
    logic                 s4_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s4_valid <= 1'b0;
        end else if (en) begin
            s4_valid <= s3_valid;
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 4; j++) begin
                    s4_t[i][j] <= WO'(t_m[i][j]);
                end
            end
        end
    end

    // ---------------- S4b: column half, scale removal, output register ----------------
    mat24_t            t_in;
    mat22_t            yp_m;
    logic [4*WO-1:0]   y_d;
    logic signed [WO-1:0] yp_e;

    always_comb begin
        t_in = '{default: 0};
        y_d  = '0;
        yp_e = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) begin
                t_in[i][j] = int'(s4_t[i][j]);
            end
        end
        yp_m = out_col_xform(t_in);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                yp_e = WO'(yp_m[i][j]);
                y_d[idx_y(i, j)*WO +: WO] = yp_e >>> G_SHIFT;
            end
        end
    end

    // Y only loads with a new result, so it stays put while stalled and
    // also between results.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            Y         <= '0;
        end else if (en) begin
            out_valid <= s4_valid;
            if (s4_valid) begin
                Y <= y_d;
            end
        end
    end

endmodule

// File: tb/tb_wino_conv_tile_acc.sv
module tb_wino_conv_tile_acc;
    import wino_pkg::*;

    localparam int WI = 8;
    localparam int WO = 32;

    typedef int arr16_t [16];

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_last = 1'b0;
    logic [9*WI-1:0]  filter = '0;
    logic [16*WI-1:0] data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [4*WO-1:0]  Y;

    int checks = 0;
    int errors = 0;
    logic [4*WO-1:0] exp_q [$];
    bit rand_ready  = 1'b0;
    bit force_stall = 1'b0;
    int macc [2][2] = '{default: 0};

    always #5 clk = ~clk;

    wino_conv_tile_acc dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .filter    (filter),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y)
    );

    function automatic logic [4*WO-1:0] pack_y(input int y00, input int y01, input int y10, input int y11);
        return {32'(y11), 32'(y10), 32'(y01), 32'(y00)};
    endfunction

    function automatic logic [16*WI-1:0] pack_d(input arr16_t v);
        logic [16*WI-1:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[k*WI +: WI] = WI'(v[k]);
        return r;
    endfunction

    function automatic logic [16*WI-1:0] fill_d(input int v);
        logic [16*WI-1:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[k*WI +: WI] = WI'(v);
        return r;
    endfunction

    function automatic logic [9*WI-1:0] fill_f(input int v);
        logic [9*WI-1:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[k*WI +: WI] = WI'(v);
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Direct 3x3 convolution reference, summed over the channels of a group.
    task automatic model_beat(input logic [9*WI-1:0] f, input logic [16*WI-1:0] d, input bit last);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                for (int a = 0; a < 3; a++)
                    for (int b = 0; b < 3; b++)
                        macc[i][j] += int'(signed'(f[(3*a+b)*WI +: WI])) *
                                      int'(signed'(d[(4*(i+a)+(j+b))*WI +: WI]));
        if (last) begin
            exp_q.push_back(pack_y(macc[0][0], macc[0][1], macc[1][0], macc[1][1]));
            macc = '{default: 0};
        end
    endtask

    task automatic send_beat(input logic [9*WI-1:0] f, input logic [16*WI-1:0] d,
                             input bit last, input bit use_model);
        int  waited;
        bit  done;
        bit  rdy;
        waited = 0;
        done   = 1'b0;
        if (use_model) model_beat(f, d, last);
        @(negedge clk);
        filter   = f;
        data     = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!done) begin
            #1;
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 2000) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_accept: got no in_ready expected acceptance within 2000 cycles");
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        check(name, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            out_ready = force_stall ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    initial begin
        logic [4*WO-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rstn && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL y_unexpected: got %h expected no output", Y);
                end else begin
                    e = exp_q.pop_front();
                    if (Y !== e) begin
                        errors++;
                        $display("FAIL y_out: got %h expected %h", Y, e);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        arr16_t           v;
        logic [9*WI-1:0]  fr;
        logic [16*WI-1:0] dr;
        logic [9*WI-1:0]  fc;
        int               lat;
        int               n;
        int               nch;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_y", 128'(Y), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        rstn = 1'b1;
        #1;
        check("in_ready_after_rst", 128'(in_ready), 128'(1));

        // 1: single-beat identity group, latency and one-cycle pulse
        exp_q.push_back(pack_y(9, 9, 9, 9));
        send_beat(fill_f(1), fill_d(1), 1'b1, 1'b0);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (out_valid && lat == 0) lat = k;
            if (lat != 0) break;
        end
        check("latency", 128'(lat), 128'(4));
        @(posedge clk);
        #1;
        check("out_valid_pulse", 128'(out_valid), 128'(0));
        wait_drain("drain_t1");

        // 2: four-channel group
        exp_q.push_back(pack_y(36, 36, 36, 36));
        for (int k = 0; k < 4; k++) send_beat(fill_f(1), fill_d(1), k == 3, 1'b0);
        wait_drain("drain_t2");

        // 3: sign and shape
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) v[4*r+c] = 4*r + c - 8;
        fc = '0;
        fc[4*WI +: WI] = 8'd1;
        exp_q.push_back(pack_y(-3, -2, 1, 2));
        send_beat(fc, pack_d(v), 1'b1, 1'b0);
        exp_q.push_back(pack_y(-18, -18, -18, -18));
        send_beat(fill_f(-1), fill_d(2), 1'b1, 1'b0);
        wait_drain("drain_t3");

        // 4: backpressure with streaming input
        force_stall = 1'b1;
        fork
            begin
                exp_q.push_back(pack_y(9, 9, 9, 9));
                send_beat(fill_f(1), fill_d(1), 1'b1, 1'b0);
                for (int g = 0; g < 5; g++) begin
                    for (int k = 0; k < 16; k++) v[k] = 3*g - k;
                    send_beat(fill_f(g - 2), pack_d(v), 1'b1, 1'b1);
                end
            end
            begin
                n = 0;
                while (n < 50) begin
                    @(negedge clk);
                    #2;
                    if (out_valid) break;
                    n++;
                end
                check("stall_out_valid_seen", 128'(out_valid), 128'(1));
                for (int k = 0; k < 5; k++) begin
                    check("stall_in_ready", 128'(in_ready), 128'(0));
                    check("stall_y_hold", 128'(Y), 128'(pack_y(9, 9, 9, 9)));
                    @(negedge clk);
                    #2;
                end
                force_stall = 1'b0;
            end
        join
        wait_drain("drain_t4");

        // 5: bubbles, then reset mid-group discards the partial sum
        send_beat(fill_f(1), fill_d(1), 1'b0, 1'b0);
        send_beat(fill_f(1), fill_d(1), 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        exp_q.push_back(pack_y(9, 9, 9, 9));
        send_beat(fill_f(1), fill_d(1), 1'b1, 1'b0);
        wait_drain("drain_t5");

        // 6: random regression against the direct convolution model
        rand_ready = 1'b1;
        for (int g = 0; g < 1000; g++) begin
            nch = $urandom_range(1, 16);
            for (int ch = 0; ch < nch; ch++) begin
                for (int k = 0; k < 9; k++) fr[k*WI +: WI] = WI'($urandom);
                for (int k = 0; k < 16; k++) dr[k*WI +: WI] = WI'($urandom);
                send_beat(fr, dr, ch == nch - 1, 1'b1);
            end
        end
        wait_drain("drain_t6");
        rand_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wino_conv_tile_acc.md
Name: wino_conv_tile_acc

Overview:
- Streaming Winograd F(2x2,3x3) convolution tile engine with input-channel accumulation in the Winograd domain.
- Per beat it accepts one 4x4 data tile and one 3x3 filter for a single input channel. It forms the element-wise product and sums products across channels until a beat tagged last, then runs one output transform.
- Adds valid/ready handshaking, backpressure and multi-channel accumulation to the existing single-tile kernel top.
- Sits between the line-buffer/tile fetcher and the output writeback.

Parameters:
- WI, 8, signed data/filter element width
- WWI, 12, signed transformed-element width (U, V)
- WWO, 24, signed product width (WWI*2)
- WACC, 28, signed Winograd-domain accumulator width
- WO, 32, signed output element width

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- in_last  in  1  beat is the last channel of the current tile group
- filter  in  9*WI  3x3 filter; element (r,c) at [(3r+c)*WI +: WI]
- data  in  16*WI  4x4 data tile; element (r,c) at [(4r+c)*WI +: WI]
- out_valid  out  1  Y valid
- out_ready  in  1  downstream accepts Y
- Y  out  4*WO  2x2 result; element (i,j) at [(2i+j)*WO +: WO]

Behaviour:
- Reset: clk rising edge with rstn=0.
  - Outputs: out_valid=0, Y=0, in_ready=0 during reset, 1 the first cycle after.
  - State: all stage valids=0, acc=0, acc_empty=1.
- Global stall: en = !out_valid || out_ready; in_ready = en.
  - No stage advances while en=0; every stage register holds.
- S1 (registered, captured when en):
  - U = B^T d B, with B^T rows [1,0,-1,0],[0,1,1,0],[0,-1,1,0],[0,1,0,-1].
  - V = G' g G'^T, with integer G' = 2G, rows [2,0,0],[1,1,1],[1,-1,1],[0,0,2].
  - Sign-extend both to WWI. in_last travels with the valid bit.
- S2: M = U .* V (16 signed products, WWO bits), registered.
- S3 accumulate, when an S2 beat is valid and en:
  - acc = (acc_empty ? 0 : acc) + sext(M) per element, mod 2^WACC (wrap, no saturation).
  - in_last=1 → sum handed to S4 and acc_empty set to 1. Otherwise acc_empty cleared.
  - in_last=1 on the first beat of a group gives a single-channel result.
- S4:
  - Y' = A^T S A, with A^T rows [1,1,1,0],[0,1,-1,-1]; computed at WO bits, sign-extended.
  - Y = Y' >>> 2 (arithmetic, removes the G' scaling; exact for integer inputs).
  - Registered into Y; out_valid set.
- Latency:
  - The last beat accepted at edge t gives out_valid=1 at edge t+4 when unstalled.
  - Throughput: 1 beat/cycle.
- Output handshake:
  - Y is held stable while out_valid && !out_ready.
  - out_valid clears on acceptance unless a new result is written in the same cycle. Back-to-back results are allowed.
- Boundaries:
  - Bubbles (in_valid=0) do not disturb acc.
  - Groups are contiguous and never interleaved.
  - Reset mid-group discards the partial acc and all in-flight beats; no output is produced.
  - Overflow beyond WACC wraps silently.

Decomposition:
- Shared package wino_pkg:
  - B^T/G'/A^T coefficient constants
  - tile packing index functions
  - default widths
  - the G'-scaling shift constant (2)
- One natural sub-module: wino_acc_stage (S3 accumulator + acc_empty/last control). Transforms are combinational functions from the package.

Test Plan:
1. Identity group of one beat: data all 1, filter all 1, in_last=1 → 4 cycles later Y=[9,9,9,9], out_valid for 1 cycle (out_ready=1).
2. Four-channel group: 4 consecutive beats as in test 1, last on beat 4 → single output Y=[36,36,36,36], no intermediate out_valid.
3. Sign and shape: filter center=1 (others 0), data (r,c)=4r+c-8, in_last=1 → Y=[-3,-2,1,2]. Filter all -1 with data all 2 → Y=[-18,-18,-18,-18].
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 streaming → in_ready=0 while stalled, Y unchanged, and no beat lost. Results match the golden model in order after release.
5. Bubbles plus reset mid-group: 2 beats, 3 idle cycles, rstn=0 for 1 cycle, then a new 1-beat group of test 1 → only Y=[9,9,9,9] emitted (prior partial discarded).
6. Random regression: 1000 groups of 1..16 channels with random signed data/filter and random out_ready → all outputs match a direct 3x3 convolution sum model.
